rv32_branch_predictor: RTL and testbench

RV32_BRANCH_PREDICTOR -- requirements
Module: rv32_branch_predictor

---
 rtl/rv32_branch_predictor.sv | 115 +++++++++++
 tb/tb_rv32_branch_predictor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// One-cycle registered lookup, same-edge table update, and mispredict statistics.
module rv32_branch_predictor #(
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned TAG_BITS     = 8,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_valid_in,
  input  logic [31:0] lookup_pc_in,
  input  logic        stall_in,
  output logic        predict_valid_out,
  output logic        predicted_taken_out,
  output logic [31:0] predicted_pc_out,
  input  logic        update_valid_in,
  input  logic [31:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [31:0] update_target_in,
  input  logic        update_predicted_taken_in,
  output logic        mispredicted_out,
  output logic [31:0] mispredict_count_out
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned TGT_BITS = 31;
  localparam int unsigned IDX_LO   = 2;
  localparam int unsigned TAG_LO   = INDEX_BITS + 2;

  localparam logic [COUNTER_BITS-1:0] CTR_MAX     = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK_T  = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - COUNTER_BITS'(1);

  logic                    valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]     tag_q    [ENTRIES];
  logic [TGT_BITS-1:0]     target_q [ENTRIES];
  logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0]   lk_idx_c, up_idx_c;
  logic [TAG_BITS-1:0]     lk_tag_c, up_tag_c;
  logic                    lk_hit_c, lk_taken_c, up_hit_c, mispredict_c;
  logic [COUNTER_BITS-1:0] up_ctr_c, up_ctr_nxt_c;
  logic                    unused_pc_bits;

  assign lk_idx_c = lookup_pc_in[INDEX_BITS+IDX_LO-1:IDX_LO];
  assign lk_tag_c = lookup_pc_in[TAG_BITS+TAG_LO-1:TAG_LO];
  assign up_idx_c = update_pc_in[INDEX_BITS+IDX_LO-1:IDX_LO];
  assign up_tag_c = update_pc_in[TAG_BITS+TAG_LO-1:TAG_LO];

  assign unused_pc_bits = ^{update_pc_in, update_target_in[0]};

  assign lk_hit_c     = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
  assign lk_taken_c   = lk_hit_c && ctr_q[lk_idx_c][COUNTER_BITS-1];
  assign up_hit_c     = valid_q[up_idx_c] && (tag_q[up_idx_c] == up_tag_c);
  assign up_ctr_c     = ctr_q[up_idx_c];
  assign mispredict_c = update_valid_in && (update_taken_in != update_predicted_taken_in);

  // Saturating counter step for the entry being trained
  always_comb begin
    up_ctr_nxt_c = up_ctr_c;
    if (update_taken_in) begin
      if (up_ctr_c != CTR_MAX) up_ctr_nxt_c = up_ctr_c + COUNTER_BITS'(1);
    end else begin
      if (up_ctr_c != '0) up_ctr_nxt_c = up_ctr_c - COUNTER_BITS'(1);
    end
  end

  // Table storage; non-blocking writes give read-before-write to a same-cycle lookup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (update_valid_in) begin
      if (up_hit_c) begin
        ctr_q[up_idx_c] <= up_ctr_nxt_c;
        if (update_taken_in) target_q[up_idx_c] <= update_target_in[31:1];
      end else begin
        valid_q[up_idx_c]  <= 1'b1;
        tag_q[up_idx_c]    <= up_tag_c;
        target_q[up_idx_c] <= update_target_in[31:1];
        ctr_q[up_idx_c]    <= update_taken_in ? CTR_WEAK_T : CTR_WEAK_NT;
      end
    end
  end

  // Lookup result registers, frozen while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      predict_valid_out   <= 1'b0;
      predicted_taken_out <= 1'b0;
      predicted_pc_out    <= '0;
    end else if (!stall_in) begin
      predict_valid_out   <= lookup_valid_in;
      predicted_taken_out <= lk_taken_c;
      predicted_pc_out    <= lk_taken_c ? {target_q[lk_idx_c], 1'b0} : lookup_pc_in + 32'd4;
    end
  end

  // Count advances on the same edge that raises the flag, so both are visible together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredicted_out     <= 1'b0;
      mispredict_count_out <= '0;
    end else begin
      mispredicted_out <= mispredict_c;
      if (mispredict_c && (mispredict_count_out != 32'hFFFF_FFFF))
        mispredict_count_out <= mispredict_count_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed bench for rv32_branch_predictor: hand-computed vectors, inline checks per scenario.
module tb_rv32_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid_in;
  logic [31:0] lookup_pc_in;
  logic        stall_in;
  logic        predict_valid_out;
  logic        predicted_taken_out;
  logic [31:0] predicted_pc_out;
  logic        update_valid_in;
  logic [31:0] update_pc_in;
  logic        update_taken_in;
  logic [31:0] update_target_in;
  logic        update_predicted_taken_in;
  logic        mispredicted_out;
  logic [31:0] mispredict_count_out;

  int vectors = 0;
  int miscompares = 0;

  rv32_branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8), .COUNTER_BITS(2)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .lookup_valid_in           (lookup_valid_in),
    .lookup_pc_in              (lookup_pc_in),
    .stall_in                  (stall_in),
    .predict_valid_out         (predict_valid_out),
    .predicted_taken_out       (predicted_taken_out),
    .predicted_pc_out          (predicted_pc_out),
    .update_valid_in           (update_valid_in),
    .update_pc_in              (update_pc_in),
    .update_taken_in           (update_taken_in),
    .update_target_in          (update_target_in),
    .update_predicted_taken_in (update_predicted_taken_in),
    .mispredicted_out          (mispredicted_out),
    .mispredict_count_out      (mispredict_count_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid_in = 1'b0;
    lookup_pc_in = '0;
    stall_in = 1'b0;
    update_valid_in = 1'b0;
    update_pc_in = '0;
    update_taken_in = 1'b0;
    update_target_in = '0;
    update_predicted_taken_in = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_valid_in = 1'b1;
    lookup_pc_in = pc;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic pred);
    update_valid_in = 1'b1;
    update_pc_in = pc;
    update_taken_in = taken;
    update_target_in = tgt;
    update_predicted_taken_in = pred;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    vectors++; if (predict_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", predict_valid_out); end
    vectors++; if (predicted_taken_out !== 1'b0) begin miscompares++; $display("FAIL reset_taken got %b want 0", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", predicted_pc_out); end
    vectors++; if (mispredicted_out !== 1'b0) begin miscompares++; $display("FAIL reset_mispred got %b want 0", mispredicted_out); end
    vectors++; if (mispredict_count_out !== 32'h0) begin miscompares++; $display("FAIL reset_count got %h want 0", mispredict_count_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cold_lookup();
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predict_valid_out !== 1'b1) begin miscompares++; $display("FAIL cold_valid got %b want 1", predict_valid_out); end
    vectors++; if (predicted_taken_out !== 1'b0) begin miscompares++; $display("FAIL cold_taken got %b want 0", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_1004) begin miscompares++; $display("FAIL cold_pc got %h want 00001004", predicted_pc_out); end
    idle(); step();
    vectors++; if (predict_valid_out !== 1'b0) begin miscompares++; $display("FAIL novalid got %b want 0", predict_valid_out); end
    idle(); lookup(32'hFFFF_FFFC); step();
    vectors++; if (predicted_pc_out !== 32'h0) begin miscompares++; $display("FAIL pc_wrap got %h want 00000000", predicted_pc_out); end
  endtask

  task automatic test_alloc_taken();
    idle(); upd(32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1); step();
    vectors++; if (mispredicted_out !== 1'b0) begin miscompares++; $display("FAIL alloc_mispred got %b want 0", mispredicted_out); end
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predicted_taken_out !== 1'b1) begin miscompares++; $display("FAIL alloc_taken got %b want 1", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_2000) begin miscompares++; $display("FAIL alloc_pc got %h want 00002000", predicted_pc_out); end
  endtask

  task automatic test_saturate_low();
    // counter 2 -> 1 -> 0 -> 0, then taken -> 1 (still not-taken)
    for (int i = 0; i < 3; i++) begin
      idle(); upd(32'h0000_1000, 1'b0, 32'h0, 1'b0); step();
    end
    idle(); lookup(32'h0000_1000); upd(32'h0000_1000, 1'b1, 32'h0000_3000, 1'b1); step();
    vectors++; if (predicted_taken_out !== 1'b0) begin miscompares++; $display("FAIL sat0_taken got %b want 0", predicted_taken_out); end
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predicted_taken_out !== 1'b0) begin miscompares++; $display("FAIL sat0_inc_taken got %b want 0", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_1004) begin miscompares++; $display("FAIL sat0_inc_pc got %h want 00001004", predicted_pc_out); end
  endtask

  task automatic test_alias();
    idle(); lookup(32'h0000_1100); step();
    vectors++; if (predicted_taken_out !== 1'b0) begin miscompares++; $display("FAIL alias_miss_taken got %b want 0", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_1104) begin miscompares++; $display("FAIL alias_miss_pc got %h want 00001104", predicted_pc_out); end
    idle(); upd(32'h0000_1100, 1'b1, 32'h0000_4000, 1'b1); step();
    idle(); lookup(32'h0000_1100); step();
    vectors++; if (predicted_pc_out !== 32'h0000_4000) begin miscompares++; $display("FAIL alias_hit_pc got %h want 00004000", predicted_pc_out); end
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predicted_pc_out !== 32'h0000_1004) begin miscompares++; $display("FAIL evicted_pc got %h want 00001004", predicted_pc_out); end
  endtask

  task automatic test_same_cycle();
    idle(); upd(32'h0000_1000, 1'b0, 32'h0000_2000, 1'b0); step();
    idle(); lookup(32'h0000_1000); upd(32'h0000_1000, 1'b1, 32'h0000_5000, 1'b0); step();
    vectors++; if (predicted_taken_out !== 1'b0) begin miscompares++; $display("FAIL rbw_taken got %b want 0", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_1004) begin miscompares++; $display("FAIL rbw_pc got %h want 00001004", predicted_pc_out); end
    vectors++; if (mispredicted_out !== 1'b1) begin miscompares++; $display("FAIL mispred_flag got %b want 1", mispredicted_out); end
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predicted_pc_out !== 32'h0000_5000) begin miscompares++; $display("FAIL rbw_new_pc got %h want 00005000", predicted_pc_out); end
    vectors++; if (mispredicted_out !== 1'b0) begin miscompares++; $display("FAIL mispred_clear got %b want 0", mispredicted_out); end
    vectors++; if (mispredict_count_out !== 32'd1) begin miscompares++; $display("FAIL mispred_count got %0d want 1", mispredict_count_out); end
  endtask

  task automatic test_saturate_high();
    // counter 2 -> 3 -> 3, then not-taken -> 2 keeps predicting taken
    for (int i = 0; i < 2; i++) begin
      idle(); upd(32'h0000_1000, 1'b1, 32'h0000_5000, 1'b1); step();
    end
    idle(); upd(32'h0000_1000, 1'b0, 32'h0, 1'b0); step();
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predicted_taken_out !== 1'b1) begin miscompares++; $display("FAIL sat3_taken got %b want 1", predicted_taken_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_5000) begin miscompares++; $display("FAIL sat3_pc got %h want 00005000", predicted_pc_out); end
  endtask

  task automatic test_stall();
    idle(); lookup(32'h0000_1000); step();
    idle(); stall_in = 1'b1; upd(32'h0000_2000, 1'b1, 32'h0000_6000, 1'b1); step();
    vectors++; if (predict_valid_out !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %b want 1", predict_valid_out); end
    vectors++; if (predicted_pc_out !== 32'h0000_5000) begin miscompares++; $display("FAIL stall_pc got %h want 00005000", predicted_pc_out); end
    idle(); stall_in = 1'b1; lookup(32'h0000_2000); step();
    vectors++; if (predicted_pc_out !== 32'h0000_5000) begin miscompares++; $display("FAIL stall_hold_pc got %h want 00005000", predicted_pc_out); end
    idle(); lookup(32'h0000_2000); step();
    vectors++; if (predicted_pc_out !== 32'h0000_6000) begin miscompares++; $display("FAIL stall_upd_pc got %h want 00006000", predicted_pc_out); end
  endtask

  task automatic test_reset_mid_update();
    idle(); upd(32'h0000_1000, 1'b1, 32'h0000_7000, 1'b0); stall_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (predict_valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b want 0", predict_valid_out); end
    @(negedge clk);
    reset = 1'b0;
    idle(); lookup(32'h0000_1000); step();
    vectors++; if (predicted_pc_out !== 32'h0000_1004) begin miscompares++; $display("FAIL rst_cold_pc got %h want 00001004", predicted_pc_out); end
    vectors++; if (mispredict_count_out !== 32'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", mispredict_count_out); end
  endtask

  initial begin
    test_reset();
    test_cold_lookup();
    test_alloc_taken();
    test_saturate_low();
    test_alias();
    test_same_cycle();
    test_saturate_high();
    test_stall();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
